ecc_inject_pipe: RTL and testbench



---
 rtl/ecc_inject_pipe.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ecc_inject_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_inject_pipe.sv
// Pipelined multi-lane SECDED encode / fault-inject / decode harness with saturating statistics.
// Optional first-failure capture ports are enabled by defining ECC_FIRST_FAIL_CAPTURE_EN.

module ecc_encode (
  input  logic [31:0] data,
  output logic [38:0] code
);
  // Hamming(38,32) at positions 1..38 with overall parity in bit 0.
  always_comb begin : enc_calc
    logic [38:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[6'(p)] = data[5'(k)];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      for (int p = 1; p < 39; p++) begin
        if ((((p >> i) & 1) == 1) && (p != (1 << i))) begin
          c[6'(1 << i)] = c[6'(1 << i)] ^ c[6'(p)];
        end
      end
    end
    c[0] = ^c[38:1];
    code = c;
  end
endmodule

module ecc_decode (
  input  logic [38:0] code,
  output logic [31:0] data,
  output logic        single_error,
  output logic        double_error
);
  always_comb begin : dec_calc
    logic [5:0]  syn;
    logic [38:1] c;
    int k;
    syn          = '0;
    c            = code[38:1];
    k            = 0;
    data         = '0;
    single_error = 1'b0;
    double_error = 1'b0;
    for (int p = 1; p < 39; p++) begin
      if (code[6'(p)]) syn = syn ^ 6'(p);
    end
    // Odd overall parity with an out-of-range syndrome can only be a multi-bit error.
    if (^code) begin
      if (syn > 6'd38) begin
        double_error = 1'b1;
      end else begin
        single_error = 1'b1;
        if (syn != 6'd0) c[syn] = ~c[syn];
      end
    end else if (syn != 6'd0) begin
      double_error = 1'b1;
    end
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[5'(k)] = c[6'(p)];
        k++;
      end
    end
  end
endmodule

module ecc_inject_pipe #(
  parameter int          LANES     = 2,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  input  logic [1:0]            inj_mode,
  input  logic [LANES-1:0]      lane_mask,
  input  logic [2:0]            fix_en,
  input  logic [5:0]            fail_loc_0,
  input  logic [5:0]            fail_loc_1,
  input  logic [5:0]            fail_loc_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_single,
  output logic [LANES-1:0]      out_double,
  output logic                  out_mismatch,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      cnt_words,
  output logic [CNT_W-1:0]      cnt_single,
  output logic [CNT_W-1:0]      cnt_double,
  output logic [CNT_W-1:0]      cnt_mismatch
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
  ,
  output logic                  ff_valid,
  output logic [CNT_W-1:0]      ff_index,
  output logic [32*LANES-1:0]   ff_data
`endif
);
  localparam int DATA_W = 32 * LANES;

  logic                       advance, in_hs, out_hs;
  logic [15:0]                lfsr_q, lfsr_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]          s1_data_q, s1_data_d;
  logic [LANES-1:0][38:0]     s1_code_q, s1_code_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]          s2_data_q, s2_data_d;
  logic [DATA_W-1:0]          s2_orig_q, s2_orig_d;
  logic [LANES-1:0]           s2_single_q, s2_single_d;
  logic [LANES-1:0]           s2_double_q, s2_double_d;
  logic [CNT_W-1:0]           words_q, words_d, single_q, single_d;
  logic [CNT_W-1:0]           double_q, double_d, mism_q, mism_d;
  logic [LANES-1:0][38:0]     enc_code, inj_code;
  logic [DATA_W-1:0]          dec_data;
  logic [LANES-1:0]           dec_single, dec_double;
  logic [38:0]                flip;
  logic [5:0]                 l1, off;
  logic [6:0]                 l2;
  logic [2:0][5:0]            locs;
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
  logic                       ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0]           ff_index_q, ff_index_d;
  logic [DATA_W-1:0]          ff_data_q, ff_data_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ecc_encode u_enc (
      .data (in_data[32*k +: 32]),
      .code (enc_code[k])
    );
    ecc_decode u_dec (
      .code         (s1_code_q[k]),
      .data         (dec_data[32*k +: 32]),
      .single_error (dec_single[k]),
      .double_error (dec_double[k])
    );
  end

  assign advance      = !s2_valid_q || out_ready;
  assign in_ready     = advance;
  assign in_hs        = in_valid && advance;
  assign out_hs       = s2_valid_q && out_ready;
  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_single   = s2_single_q;
  assign out_double   = s2_double_q;
  assign out_mismatch = (s2_data_q != s2_orig_q);
  assign cnt_words    = words_q;
  assign cnt_single   = single_q;
  assign cnt_double   = double_q;
  assign cnt_mismatch = mism_q;
  assign locs         = {fail_loc_2, fail_loc_1, fail_loc_0};

  // Random locations: l2 is l1 plus a nonzero offset modulo 39, so the two flips never coincide.
  always_comb begin
    flip = '0;
    l1   = lfsr_q[5:0];
    if (l1 >= 6'd39) l1 = l1 - 6'd39;
    off  = lfsr_q[11:6];
    if (off >= 6'd38) off = off - 6'd38;
    off  = off + 6'd1;
    l2   = {1'b0, l1} + {1'b0, off};
    if (l2 >= 7'd39) l2 = l2 - 7'd39;
    case (inj_mode)
      2'd1: begin
        for (int i = 0; i < 3; i++) begin
          if (fix_en[i] && (locs[i] < 6'd39)) flip[locs[i]] = ~flip[locs[i]];
        end
      end
      2'd2: flip[l1] = 1'b1;
      2'd3: begin
        flip[l1]      = 1'b1;
        flip[l2[5:0]] = 1'b1;
      end
      default: flip = '0;
    endcase
    for (int k = 0; k < LANES; k++) begin
      inj_code[k] = enc_code[k] ^ (lane_mask[k] ? flip : 39'd0);
    end
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_code_d   = s1_code_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_orig_d   = s2_orig_q;
    s2_single_d = s2_single_q;
    s2_double_d = s2_double_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_hs) begin
        s1_data_d = in_data;
        s1_code_d = inj_code;
      end
      if (s1_valid_q) begin
        s2_data_d   = dec_data;
        s2_orig_d   = s1_data_q;
        s2_single_d = dec_single;
        s2_double_d = dec_double;
      end
    end
    if (in_hs) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_comb begin
    words_d  = words_q;
    single_d = single_q;
    double_d = double_q;
    mism_d   = mism_q;
    if (clr_cnt) begin
      words_d  = '0;
      single_d = '0;
      double_d = '0;
      mism_d   = '0;
    end else if (out_hs) begin
      words_d = sat_inc(words_q);
      if (|s2_single_q) single_d = sat_inc(single_q);
      if (|s2_double_q) double_d = sat_inc(double_q);
      if (out_mismatch) mism_d   = sat_inc(mism_q);
    end
  end

`ifdef ECC_FIRST_FAIL_CAPTURE_EN
  assign ff_valid = ff_valid_q;
  assign ff_index = ff_index_q;
  assign ff_data  = ff_data_q;

  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_index_d = ff_index_q;
    ff_data_d  = ff_data_q;
    if (clr_cnt) begin
      ff_valid_d = 1'b0;
      ff_index_d = '0;
      ff_data_d  = '0;
    end else if (out_hs && !ff_valid_q && (out_mismatch || (|s2_double_q))) begin
      ff_valid_d = 1'b1;
      ff_index_d = words_q;
      ff_data_d  = s2_orig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_index_q <= '0;
      ff_data_q  <= '0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_index_q <= ff_index_d;
      ff_data_q  <= ff_data_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_SEED;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_code_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_orig_q   <= '0;
      s2_single_q <= '0;
      s2_double_q <= '0;
      words_q     <= '0;
      single_q    <= '0;
      double_q    <= '0;
      mism_q      <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_code_q   <= s1_code_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_orig_q   <= s2_orig_d;
      s2_single_q <= s2_single_d;
      s2_double_q <= s2_double_d;
      words_q     <= words_d;
      single_q    <= single_d;
      double_q    <= double_d;
      mism_q      <= mism_d;
    end
  end
endmodule

// File: tb/tb_ecc_inject_pipe.sv
// Randomized self-checking bench for ecc_inject_pipe: a 16-bit-counter instance plus a
// 4-bit-counter instance sharing all inputs, both checked against a behavioural model.
`timescale 1ns/1ps

module tb_ecc_inject_pipe;

   typedef struct {
      logic [63:0] orig;
      logic [63:0] data;
      logic [1:0]  single;
      logic [1:0]  dbl;
      logic        mism;
   } word_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid, inReady, outValid, outReady, clrCnt, outMismatch;
   logic [63:0] inData, outData;
   logic [1:0]  injMode, laneMask, outSingle, outDouble;
   logic [2:0]  fixEn;
   logic [5:0]  failLoc0, failLoc1, failLoc2;
   logic [15:0] cntWords, cntSingle, cntDouble, cntMismatch;
   logic        satInReady, satOutValid, satOutMismatch;
   logic [63:0] satOutData;
   logic [1:0]  satOutSingle, satOutDouble;
   logic [3:0]  satWords, satSingle, satDouble, satMismatch;
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
   logic        ffValid, satFfValid;
   logic [15:0] ffIndex;
   logic [3:0]  satFfIndex;
   logic [63:0] ffDataOut, satFfData;
`endif

   int numChecks = 0;
   int numFails  = 0;

   // Behavioural model state: two in-flight slots, raw event counts and the injection LFSR.
   bit          mv1, mv2;
   word_t       w1, w2;
   int          rawWords, rawSingle, rawDouble, rawMism;
   logic [15:0] lfsrM;
   bit          lastAccepted;
   int          accepted;
   bit          mFfValid;
   int          mFfIndex;
   logic [63:0] mFfData;

   always #5 clk = ~clk;

   ecc_inject_pipe #(.LANES(2), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .inj_mode(injMode), .lane_mask(laneMask), .fix_en(fixEn),
      .fail_loc_0(failLoc0), .fail_loc_1(failLoc1), .fail_loc_2(failLoc2),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData),
      .out_single(outSingle), .out_double(outDouble), .out_mismatch(outMismatch),
      .clr_cnt(clrCnt), .cnt_words(cntWords), .cnt_single(cntSingle),
      .cnt_double(cntDouble), .cnt_mismatch(cntMismatch)
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
      , .ff_valid(ffValid), .ff_index(ffIndex), .ff_data(ffDataOut)
`endif
   );

   ecc_inject_pipe #(.LANES(2), .CNT_W(4), .LFSR_SEED(16'hACE1)) dutSat (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(satInReady), .in_data(inData),
      .inj_mode(injMode), .lane_mask(laneMask), .fix_en(fixEn),
      .fail_loc_0(failLoc0), .fail_loc_1(failLoc1), .fail_loc_2(failLoc2),
      .out_valid(satOutValid), .out_ready(outReady), .out_data(satOutData),
      .out_single(satOutSingle), .out_double(satOutDouble), .out_mismatch(satOutMismatch),
      .clr_cnt(clrCnt), .cnt_words(satWords), .cnt_single(satSingle),
      .cnt_double(satDouble), .cnt_mismatch(satMismatch)
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
      , .ff_valid(satFfValid), .ff_index(satFfIndex), .ff_data(satFfData)
`endif
   );

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int satVal(input int raw, input int w);
      int maxV;
      maxV = (1 << w) - 1;
      return (raw > maxV) ? maxV : raw;
   endfunction

   function automatic logic [15:0] lfsrNext(input logic [15:0] l);
      int fb;
      fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return 16'((l >> 1) | (fb << 15));
   endfunction

   // Data bit carried by Hamming position p (p not a power of two): p minus parity positions below it, minus 1.
   function automatic int dataIndex(input int p);
      int lg;
      lg = 0;
      while ((1 << (lg + 1)) <= p) lg++;
      return p - lg - 2;
   endfunction

   // Expected decoder result: one flip is always corrected, two flips are flagged and left uncorrected.
   function automatic word_t predict(input logic [63:0] d, input int mode, input int mask,
                                     input int fen, input int loc0, input int loc1, input int loc2,
                                     input logic [15:0] lf);
      word_t w;
      bit [38:0] fm;
      int locs[3];
      int l1, o, l2, n;
      fm = '0;
      locs[0] = loc0; locs[1] = loc1; locs[2] = loc2;
      l1 = lf % 64;
      if (l1 >= 39) l1 -= 39;
      o = (lf / 64) % 64;
      if (o >= 38) o -= 38;
      o += 1;
      l2 = (l1 + o) % 39;
      if (mode == 1) begin
         for (int i = 0; i < 3; i++)
            if (((fen >> i) & 1) == 1 && locs[i] < 39) fm[locs[i]] = ~fm[locs[i]];
      end else if (mode == 2) begin
         fm[l1] = 1'b1;
      end else if (mode == 3) begin
         fm[l1] = 1'b1;
         fm[l2] = 1'b1;
      end
      n = $countones(fm);
      w.orig = d; w.data = d; w.single = '0; w.dbl = '0;
      for (int k = 0; k < 2; k++) begin
         if (((mask >> k) & 1) == 1) begin
            if (n == 1) w.single[k] = 1'b1;
            if (n == 2) begin
               w.dbl[k] = 1'b1;
               for (int p = 3; p < 39; p++)
                  if (fm[p] && (p & (p - 1)) != 0) w.data[32*k + dataIndex(p)] = ~w.data[32*k + dataIndex(p)];
            end
         end
      end
      w.mism = (w.data != d);
      return w;
   endfunction

   task automatic checkCounters();
      checkOutput("cnt_words", cntWords, satVal(rawWords, 16));
      checkOutput("cnt_single", cntSingle, satVal(rawSingle, 16));
      checkOutput("cnt_double", cntDouble, satVal(rawDouble, 16));
      checkOutput("cnt_mismatch", cntMismatch, satVal(rawMism, 16));
      checkOutput("sat_cnt_words", satWords, satVal(rawWords, 4));
      checkOutput("sat_cnt_single", satSingle, satVal(rawSingle, 4));
      checkOutput("sat_cnt_double", satDouble, satVal(rawDouble, 4));
      checkOutput("sat_cnt_mismatch", satMismatch, satVal(rawMism, 4));
`ifdef ECC_FIRST_FAIL_CAPTURE_EN
      checkOutput("ff_valid", ffValid, mFfValid);
      checkOutput("ff_index", ffIndex, mFfValid ? satVal(mFfIndex, 16) : 0);
      checkOutput("ff_data", ffDataOut, mFfValid ? mFfData : 64'd0);
`endif
   endtask

   // One clock cycle: drive handshake controls, advance the model, then check after the edge.
   task automatic applyStimulus(input bit v, input bit ordy, input bit clr);
      bit adv, ohs, ihs;
      inValid  = v;
      outReady = ordy;
      clrCnt   = clr;
      #1;
      adv = !mv2 || ordy;
      ohs = mv2 && ordy;
      ihs = v && adv;
      checkOutput("in_ready", inReady, adv);
      if (ohs) begin
         if (!mFfValid && (w2.mism || (|w2.dbl))) begin
            mFfValid = 1'b1;
            mFfIndex = rawWords;
            mFfData  = w2.orig;
         end
         rawWords++;
         if (|w2.single) rawSingle++;
         if (|w2.dbl) rawDouble++;
         if (w2.mism) rawMism++;
      end
      if (clr) begin
         rawWords = 0; rawSingle = 0; rawDouble = 0; rawMism = 0;
         mFfValid = 1'b0;
      end
      if (adv) begin
         if (mv1) w2 = w1;
         mv2 = mv1;
         mv1 = ihs;
         if (ihs) w1 = predict(inData, int'(injMode), int'(laneMask), int'(fixEn),
                               int'(failLoc0), int'(failLoc1), int'(failLoc2), lfsrM);
      end
      if (ihs) begin
         lfsrM = lfsrNext(lfsrM);
         accepted++;
      end
      lastAccepted = ihs;
      @(posedge clk);
      @(negedge clk);
      checkOutput("out_valid", outValid, mv2);
      if (mv2) begin
         checkOutput("out_data", outData, w2.data);
         checkOutput("out_single", outSingle, w2.single);
         checkOutput("out_double", outDouble, w2.dbl);
         checkOutput("out_mismatch", outMismatch, w2.mism);
      end
      checkCounters();
   endtask

   task automatic doReset();
      rstN    = 1'b0;
      inValid = 1'b0;
      clrCnt  = 1'b0;
      #1;
      mv1 = 0; mv2 = 0;
      rawWords = 0; rawSingle = 0; rawDouble = 0; rawMism = 0;
      lfsrM = 16'hACE1;
      mFfValid = 1'b0;
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_in_ready", inReady, 1);
      checkOutput("rst_out_data", outData, 0);
      checkOutput("rst_out_single", outSingle, 0);
      checkOutput("rst_out_double", outDouble, 0);
      checkOutput("rst_out_mismatch", outMismatch, 0);
      checkCounters();
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic setFixed(input logic [1:0] mask, input logic [2:0] fen,
                           input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      injMode = 2'd1; laneMask = mask; fixEn = fen;
      failLoc0 = a; failLoc1 = b; failLoc2 = c;
   endtask

   task automatic randomizeWord(input int mode);
      inData   = {$urandom, $urandom};
      injMode  = 2'(mode);
      laneMask = 2'($urandom_range(0, 3));
      fixEn    = 3'($urandom_range(0, 7));
      if (fixEn == 3'b111) fixEn = 3'b011;
      failLoc0 = 6'($urandom_range(0, 63));
      failLoc1 = 6'($urandom_range(0, 63));
      failLoc2 = 6'($urandom_range(0, 63));
   endtask

   // Streams a number of accepted words of one mode with random valid/ready gaps.
   task automatic runRandom(input int mode, input int words, input logic [1:0] forceMask);
      int target;
      target = accepted + words;
      randomizeWord(mode < 0 ? $urandom_range(0, 3) : mode);
      if (forceMask != 2'b00) laneMask = forceMask;
      for (int c = 0; c < 8 * words && accepted < target; c++) begin
         applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, 1'b0);
         if (lastAccepted) begin
            randomizeWord(mode < 0 ? $urandom_range(0, 3) : mode);
            if (forceMask != 2'b00) laneMask = forceMask;
         end
      end
      checkOutput("accepted_words", accepted, target);
   endtask

   task automatic drain(input int n);
      repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [63:0] bpWords[3];
      int idx;
      rstN = 1'b0; inValid = 1'b0; outReady = 1'b1; clrCnt = 1'b0;
      inData = '0; injMode = '0; laneMask = '0; fixEn = '0;
      failLoc0 = '0; failLoc1 = '0; failLoc2 = '0;
      accepted = 0; lastAccepted = 1'b0;
      doReset();

      $display("[TB] directed: clean word, single flip, double flip, cancelling flips");
      inData = 64'h01234567_DEADBEEF; injMode = 2'd0; laneMask = 2'b11; fixEn = 3'b000;
      applyStimulus(1'b1, 1'b1, 1'b0);
      drain(3);
      checkOutput("t1_words", cntWords, 1);
      setFixed(2'b11, 3'b001, 6'd5, 6'd0, 6'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      drain(3);
      checkOutput("t2_single", cntSingle, 1);
      setFixed(2'b10, 3'b011, 6'd3, 6'd20, 6'd0);
      inData = 64'hCAFEF00D_12345678;
      applyStimulus(1'b1, 1'b1, 1'b0);
      drain(3);
      checkOutput("t3_double", cntDouble, 1);
      setFixed(2'b11, 3'b011, 6'd7, 6'd7, 6'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      setFixed(2'b11, 3'b001, 6'd45, 6'd0, 6'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      drain(3);
      checkOutput("t4_single", cntSingle, 1);
      checkOutput("t4_double", cntDouble, 1);

      $display("[TB] backpressure and counter clear");
      applyStimulus(1'b0, 1'b1, 1'b1);
      bpWords[0] = 64'h11111111_AAAAAAAA;
      bpWords[1] = 64'h22222222_BBBBBBBB;
      bpWords[2] = 64'h33333333_CCCCCCCC;
      injMode = 2'd0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         inData = bpWords[idx < 3 ? idx : 2];
         applyStimulus(idx < 3, 1'b0, 1'b0);
         if (lastAccepted) idx++;
      end
      for (int c = 0; c < 10; c++) begin
         inData = bpWords[idx < 3 ? idx : 2];
         applyStimulus(idx < 3, 1'b1, 1'b0);
         if (lastAccepted) idx++;
      end
      checkOutput("bp_words", cntWords, 3);
      runRandom(0, 20, 2'b00);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("clr_words", cntWords, 0);
      drain(3);

      $display("[TB] random single and double injection");
      applyStimulus(1'b0, 1'b1, 1'b1);
      runRandom(2, 1000, 2'b11);
      drain(3);
      checkOutput("m2_single", cntSingle, 1000);
      checkOutput("m2_mismatch", cntMismatch, 0);
      checkOutput("m2_sat_words", satWords, 15);
      applyStimulus(1'b0, 1'b1, 1'b1);
      runRandom(3, 1000, 2'b11);
      drain(3);
      checkOutput("m3_double", cntDouble, 1000);
      checkOutput("m3_single", cntSingle, 0);

      $display("[TB] mixed modes and reset mid-stream");
      runRandom(-1, 300, 2'b00);
      runRandom(3, 5, 2'b11);
      doReset();
      runRandom(3, 50, 2'b11);
      drain(3);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
